decode_pipe: RTL

DECODE_PIPE -- requirements
Module: decode_pipe

---
 rtl/decode_pipe.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/decode_pipe.sv
// Two-entry (main + skid) decode stage: splits a 32-bit instruction into fields, format and illegal flag.
// Optional immediate generator enabled by defining DECODE_IMM_GEN_EN; otherwise out_imm is tied to zero.
module decode_pipe #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  localparam int unsigned FMT_W = 3;
  localparam logic [FMT_W-1:0] FMT_R = 3'd0;
  localparam logic [FMT_W-1:0] FMT_I = 3'd1;
  localparam logic [FMT_W-1:0] FMT_S = 3'd2;
  localparam logic [FMT_W-1:0] FMT_B = 3'd3;
  localparam logic [FMT_W-1:0] FMT_U = 3'd4;
  localparam logic [FMT_W-1:0] FMT_J = 3'd5;
  localparam logic [FMT_W-1:0] FMT_X = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [6:0]       opcode;
    logic [4:0]       rd;
    logic [2:0]       funct3;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [6:0]       funct7;
    logic [FMT_W-1:0] fmt;
    logic             illegal;
  } entry_t;

  entry_t dec_c, main_q, main_d, skid_q, skid_d;
  logic   main_valid, main_valid_d, skid_valid, skid_valid_d;
  logic   accept_c, main_free_c;

  // Field extraction and format classification
  always_comb begin
    dec_c        = '0;
    dec_c.pc     = in_pc;
    dec_c.opcode = in_instr[6:0];
    dec_c.rd     = in_instr[11:7];
    dec_c.funct3 = in_instr[14:12];
    dec_c.rs1    = in_instr[19:15];
    dec_c.rs2    = in_instr[24:20];
    dec_c.funct7 = in_instr[31:25];
    case (in_instr[6:0])
      7'b0110011:                         dec_c.fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b1110011, 7'b0001111:             dec_c.fmt = FMT_I;
      7'b0100011:                         dec_c.fmt = FMT_S;
      7'b1100011:                         dec_c.fmt = FMT_B;
      7'b0110111, 7'b0010111:             dec_c.fmt = FMT_U;
      7'b1101111:                         dec_c.fmt = FMT_J;
      7'b0111011:                         dec_c.fmt = (XLEN == 64) ? FMT_R : FMT_X;
      7'b0011011:                         dec_c.fmt = (XLEN == 64) ? FMT_I : FMT_X;
      default:                            dec_c.fmt = FMT_X;
    endcase
    dec_c.illegal = (dec_c.fmt == FMT_X) || (in_instr[1:0] != 2'b11);
  end

  assign accept_c    = in_valid && in_ready && !flush;
  assign main_free_c = !main_valid || out_ready;

`ifdef DECODE_IMM_GEN_EN
  logic [XLEN-1:0] imm_c, main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;

  // Sign-extended immediate per format
  always_comb begin
    imm_c = '0;
    case (dec_c.fmt)
      FMT_I:   imm_c = XLEN'($signed(in_instr[31:20]));
      FMT_S:   imm_c = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      FMT_B:   imm_c = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                      in_instr[11:8], 1'b0}));
      FMT_U:   imm_c = XLEN'($signed({in_instr[31:12], 12'b0}));
      FMT_J:   imm_c = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                      in_instr[30:21], 1'b0}));
      default: imm_c = '0;
    endcase
  end
`endif

  // Main/skid steering; skid drains into main first so order is preserved
  always_comb begin
    main_valid_d = main_valid;
    skid_valid_d = skid_valid;
    main_d       = main_q;
    skid_d       = skid_q;
`ifdef DECODE_IMM_GEN_EN
    main_imm_d   = main_imm_q;
    skid_imm_d   = skid_imm_q;
`endif
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free_c) begin
      if (skid_valid) begin
        main_valid_d = 1'b1;
        main_d       = skid_q;
`ifdef DECODE_IMM_GEN_EN
        main_imm_d   = skid_imm_q;
`endif
        skid_valid_d = accept_c;
        if (accept_c) begin
          skid_d     = dec_c;
`ifdef DECODE_IMM_GEN_EN
          skid_imm_d = imm_c;
`endif
        end
      end else begin
        main_valid_d = accept_c;
        if (accept_c) begin
          main_d     = dec_c;
`ifdef DECODE_IMM_GEN_EN
          main_imm_d = imm_c;
`endif
        end
      end
    end else if (accept_c) begin
      skid_valid_d = 1'b1;
      skid_d       = dec_c;
`ifdef DECODE_IMM_GEN_EN
      skid_imm_d   = imm_c;
`endif
    end
  end

  // in_ready held low through reset, then tracks the skid-empty state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      main_valid <= main_valid_d;
      skid_valid <= skid_valid_d;
      in_ready   <= ~skid_valid_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

`ifdef DECODE_IMM_GEN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_imm_q <= '0;
      skid_imm_q <= '0;
    end else begin
      main_imm_q <= main_imm_d;
      skid_imm_q <= skid_imm_d;
    end
  end

  assign out_imm = main_imm_q;
`else
  assign out_imm = '0;
`endif

  assign out_valid   = main_valid;
  assign out_pc      = main_q.pc;
  assign out_opcode  = main_q.opcode;
  assign out_rd      = main_q.rd;
  assign out_funct3  = main_q.funct3;
  assign out_rs1     = main_q.rs1;
  assign out_rs2     = main_q.rs2;
  assign out_funct7  = main_q.funct7;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;

endmodule
